serial_word_assembler: RTL and testbench
========================================

SERIAL_WORD_ASSEMBLER -- requirements
Module: serial_word_assembler

Interface
REQ-001 Parameter: n, 64, data word width in bits; legal range 2..64.
REQ-002 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: sin  input  1  serial data bit, typically the bit shifted out of an upstream shift register.
REQ-005 Port: sin_valid  input  1  high when sin holds a bit to be accepted this cycle.
REQ-006 Port: dir  input  1  bit order; 0 = LSB first, 1 = MSB first; sampled only with the first bit of each word.
REQ-007 Port: word_ready  input  1  downstream accepts word_out this cycle.
REQ-008 Port: word_out  output  n  assembled parallel word.
REQ-009 Port: word_valid  output  1  high while word_out holds an unconsumed word.
REQ-010 Port: busy  output  1  high while a word is partially received (bit count nonzero).
REQ-011 Port: bit_cnt  output  $clog2(n+1)  number of bits accepted for the current word.
REQ-012 Port: overrun  output  1  sticky; set when a completed word is dropped.
REQ-013 Port: parity_err  output  1  parity mismatch flag for the current word_out.

Function
REQ-014 The FSM shall have the states IDLE, SHIFT and, with the parity feature only, PARITY.
REQ-015 A bit shall be accepted on every rising edge where sin_valid=1; cycles with sin_valid=0 shall change no receive state.
REQ-016 In IDLE, an accepted bit shall latch dir, load the first bit, set bit_cnt=1 and enter SHIFT.
REQ-017 LSB-first accumulation shall be acc <= {sin, acc[n-1:1]}; MSB-first accumulation shall be acc <= {acc[n-2:0], sin}.
REQ-018 The edge that accepts the n-th data bit shall end the word: go to IDLE, or to PARITY when the parity feature is compiled in.
REQ-019 In PARITY, the edge that accepts the next bit shall end the word and return to IDLE.
REQ-020 On the word-ending edge, the completed word shall load word_out and set word_valid=1 if word_valid=0 or word_ready=1; the word is visible the cycle after its last bit.
REQ-021 On the word-ending edge, if word_valid=1 and word_ready=0, the new word shall be dropped, overrun set to 1, and word_out left unchanged.
REQ-022 A word_ready=1 cycle with no completion shall clear word_valid on the next edge.
REQ-023 Completion on the same edge as word_ready=1 with word_valid=1 shall load the new word, keep word_valid=1, and leave overrun unchanged.
REQ-024 bit_cnt shall return to 0 on the word-ending edge; busy = (bit_cnt != 0) or state = PARITY.
REQ-025 Back-to-back words with sin_valid held high shall be supported with no dead cycle between words.
REQ-026 dir changes in the middle of a word shall be ignored.

Reset
REQ-027 While reset=1: state = IDLE, acc = 0, bit_cnt = 0, word_out = 0, word_valid = 0, overrun = 0, parity_err = 0, asynchronously.
REQ-028 Reset asserted mid-word shall discard the partial word; the first accepted bit after release shall start a new word.
REQ-029 overrun shall be cleared only by reset.

Configuration
REQ-030 Macro SERIAL_WORD_ASSEMBLER_PARITY_EN defined: one even-parity bit follows the n data bits, and parity_err = (XOR of data bits) XOR (parity bit), loaded together with word_out.
REQ-031 A word with a parity error shall still be delivered normally.
REQ-032 Macro undefined: the PARITY state is absent, parity_err is tied to 0, and a word is exactly n bits.

Structure
REQ-033 Package serial_word_assembler_pkg shall hold the state enum, the DIR_LSB_FIRST/DIR_MSB_FIRST constants, and the bit-counter width function.
REQ-034 A one-entry valid/ready holding register shall be the sub-module swa_out_buf, parameterised by n+1 (word plus parity flag).

Verification (n=8)
REQ-035 LSB-first, bits 1,0,1,1,0,0,1,0 on consecutive cycles -> word_out=8'h4D, word_valid=1 the cycle after the 8th bit.
REQ-036 MSB-first, same bit sequence with random sin_valid gaps -> word_out=8'hB2; bit_cnt counts 1..7, then 0.
REQ-037 word_ready=0, words 8'h4D then 8'hFF sent -> word_out stays 8'h4D, overrun=1; word_ready=1 for one cycle then deasserts word_valid.
REQ-038 Reset pulse after 3 bits, then bits for 8'h0F -> word_out=8'h0F, no overrun, busy=0 after completion.
REQ-039 PARITY_EN, word 8'h4D with parity bit 1 -> parity_err=1; with parity bit 0 -> parity_err=0; both words delivered.
REQ-040 Completion edge coincides with word_ready=1 on a held word -> new word loaded, word_valid stays 1, overrun stays 0.

Source files
------------

// File: rtl/serial_word_assembler_pkg.sv
// Shared types and constants for the serial word assembler.
// SERIAL_WORD_ASSEMBLER_PARITY_EN adds the PARITY state for a trailing even-parity bit.
package serial_word_assembler_pkg;

`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

    // Width of a counter that must hold 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_word_assembler_if.sv
// Serial-in / parallel-out bus of the serial word assembler; the slave
// modport is the assembler, the master modport is its environment.
interface serial_word_assembler_if
    import serial_word_assembler_pkg::*;
#(
    parameter int n = 64
);
    logic                      sin;
    logic                      sin_valid;
    logic                      dir;
    logic                      word_ready;
    logic [n-1:0]              word_out;
    logic                      word_valid;
    logic                      busy;
    logic [cnt_width(n)-1:0]   bit_cnt;
    logic                      overrun;
    logic                      parity_err;

    modport slave (
        input  sin, sin_valid, dir, word_ready,
        output word_out, word_valid, busy, bit_cnt, overrun, parity_err
    );

    modport master (
        output sin, sin_valid, dir, word_ready,
        input  word_out, word_valid, busy, bit_cnt, overrun, parity_err
    );
endinterface

// File: rtl/swa_out_buf.sv
// One-entry valid/ready holding register; a load while full and not being
// drained drops the new data and sets a sticky overrun flag.
module swa_out_buf #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_overrun
);
    logic [W-1:0] r_data;
    logic         r_valid;
    logic         r_overrun;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (i_load) begin
            if (!r_valid || i_ready) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;
endmodule

// File: rtl/serial_word_assembler.sv
// Assembles n serial bits (LSB- or MSB-first) into a parallel word.
// Define SERIAL_WORD_ASSEMBLER_PARITY_EN to accept and check a trailing even-parity bit.
module serial_word_assembler
    import serial_word_assembler_pkg::*;
#(
    parameter int n = 64
) (
    input logic                    clk,
    input logic                    reset,
    serial_word_assembler_if.slave bus
);
    localparam int             CW       = cnt_width(n);
    localparam logic [CW-1:0]  LAST_IDX = CW'(n - 1);

    state_t        r_state, w_state_next;
    logic [n-1:0]  r_acc, w_acc_next, w_shifted, w_word;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_dir, w_dir_next, w_dir_eff;
    logic          w_word_end, w_perr;
    logic [n:0]    w_buf_data;
    logic          w_buf_valid, w_overrun;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_dir   <= DIR_LSB_FIRST;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_dir   <= w_dir_next;
        end
    end

    always_comb begin
        // The first bit of a word uses the live dir; later bits use the latched one.
        w_dir_eff    = (r_state == IDLE) ? bus.dir : r_dir;
        w_shifted    = (w_dir_eff == DIR_MSB_FIRST) ? {r_acc[n-2:0], bus.sin}
                                                    : {bus.sin, r_acc[n-1:1]};
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_dir_next   = r_dir;
        w_word_end   = 1'b0;
        w_word       = w_shifted;
        w_perr       = 1'b0;
        if (bus.sin_valid) begin
            case (r_state)
                IDLE: begin
                    w_dir_next   = bus.dir;
                    w_acc_next   = w_shifted;
                    w_cnt_next   = CW'(1);
                    w_state_next = SHIFT;
                end
                SHIFT: begin
                    w_acc_next = w_shifted;
                    if (r_cnt == LAST_IDX) begin
                        w_cnt_next = '0;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = IDLE;
                        w_word_end   = 1'b1;
`endif
                    end else begin
                        w_cnt_next = r_cnt + CW'(1);
                    end
                end
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
                PARITY: begin
                    w_state_next = IDLE;
                    w_word_end   = 1'b1;
                    w_word       = r_acc;
                    w_perr       = (^r_acc) ^ bus.sin;
                end
`endif
                default: w_state_next = IDLE;
            endcase
        end
    end

    swa_out_buf #(
        .W (n + 1)
    ) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_word_end),
        .i_data    ({w_perr, w_word}),
        .i_ready   (bus.word_ready),
        .o_data    (w_buf_data),
        .o_valid   (w_buf_valid),
        .o_overrun (w_overrun)
    );

    assign bus.word_out   = w_buf_data[n-1:0];
    assign bus.parity_err = w_buf_data[n];
    assign bus.word_valid = w_buf_valid;
    assign bus.overrun    = w_overrun;
    assign bus.bit_cnt    = r_cnt;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
    assign bus.busy = (r_cnt != '0) || (r_state == PARITY);
`else
    assign bus.busy = (r_cnt != '0);
`endif
endmodule

// File: tb/tb_serial_word_assembler.sv
// Scoreboard bench for serial_word_assembler at n=8; expected words are
// queued as bits are driven and popped when the word appears.
module tb_serial_word_assembler;
    import serial_word_assembler_pkg::*;

    localparam int N = 8;

    typedef struct packed {
        logic [N-1:0] word;
        logic         perr;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_word_assembler_if #(.n(N)) bus ();
    serial_word_assembler #(.n(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // seq[0] is the first bit on the wire.
    function automatic logic [N-1:0] model_word(input logic [0:N-1] seq, input logic d);
        logic [N-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++) begin
            if (d == DIR_LSB_FIRST) w[i] = seq[i];
            else                    w[N-1-i] = seq[i];
        end
        return w;
    endfunction

    task automatic drive_bit(input logic b, input logic d);
        bus.sin       = b;
        bus.dir       = d;
        bus.sin_valid = 1'b1;
        @(posedge clk); #1;
        bus.sin_valid = 1'b0;
    endtask

    // Drives one word, flipping dir after the first bit, and queues the expectation.
    task automatic send_word(input logic [0:N-1] seq, input logic d, input logic par, input int gap_max);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
            drive_bit(seq[i], (i == 0) ? d : ~d);
        end
        e.word = model_word(seq, d);
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
        drive_bit(par, ~d);
        e.perr = (^e.word) ^ par;
`else
        e.perr = 1'b0 & par;
`endif
        exp_q.push_back(e);
    endtask

    task automatic consume();
        bus.word_ready = 1'b1;
        @(posedge clk); #1;
        bus.word_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.sin = 1'b0; bus.sin_valid = 1'b0; bus.dir = 1'b0; bus.word_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (bus.word_out !== 8'h00) $display("FAIL reset_word_out got %h want 00", bus.word_out); else n_pass++;
        n_total++; if (bus.word_valid !== 1'b0) $display("FAIL reset_word_valid got %b want 0", bus.word_valid); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.bit_cnt !== 4'd0) $display("FAIL reset_bit_cnt got %0d want 0", bus.bit_cnt); else n_pass++;
        n_total++; if (bus.overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", bus.overrun); else n_pass++;
        n_total++; if (bus.parity_err !== 1'b0) $display("FAIL reset_parity_err got %b want 0", bus.parity_err); else n_pass++;
        reset = 1'b0;
        @(posedge clk); #1;
        $display("reset: done");
    endtask

    task automatic test_lsb_first();
        logic [0:N-1] seq = 8'b10110010;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            drive_bit(seq[i], (i == 0) ? DIR_LSB_FIRST : DIR_MSB_FIRST);
            if (i == N - 2) begin
                n_total++; if (bus.word_valid !== 1'b0) $display("FAIL lsb_early_valid got %b want 0", bus.word_valid); else n_pass++;
            end
        end
        e.word = model_word(seq, DIR_LSB_FIRST);
        e.perr = 1'b0;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
        drive_bit(1'b0, DIR_LSB_FIRST);
        e.perr = ^e.word;
`endif
        exp_q.push_back(e);
        e = exp_q.pop_front();
        n_total++; if (bus.word_valid !== 1'b1) $display("FAIL lsb_valid got %b want 1", bus.word_valid); else n_pass++;
        n_total++; if (bus.word_out !== e.word) $display("FAIL lsb_word got %h want %h", bus.word_out, e.word); else n_pass++;
        n_total++; if (bus.word_out !== 8'h4D) $display("FAIL lsb_word_const got %h want 4d", bus.word_out); else n_pass++;
        n_total++; if (bus.parity_err !== e.perr) $display("FAIL lsb_perr got %b want %b", bus.parity_err, e.perr); else n_pass++;
        consume();
        n_total++; if (bus.word_valid !== 1'b0) $display("FAIL lsb_consume got %b want 0", bus.word_valid); else n_pass++;
        $display("lsb_first: word %h", e.word);
    endtask

    task automatic test_msb_first();
        logic [0:N-1] seq = 8'b10110010;
        logic [3:0]   exp_cnt;
        int           gap;
        exp_t         e;
        for (int i = 0; i < N; i++) begin
            gap = int'($urandom_range(3, 0));
            repeat (gap) begin @(posedge clk); #1; end
            if (gap > 0) begin
                exp_cnt = 4'(i);
                n_total++; if (bus.bit_cnt !== exp_cnt) $display("FAIL msb_gap_cnt got %0d want %0d", bus.bit_cnt, exp_cnt); else n_pass++;
            end
            drive_bit(seq[i], (i == 0) ? DIR_MSB_FIRST : DIR_LSB_FIRST);
            exp_cnt = (i == N - 1) ? 4'd0 : 4'(i + 1);
            n_total++; if (bus.bit_cnt !== exp_cnt) $display("FAIL msb_bit_cnt got %0d want %0d", bus.bit_cnt, exp_cnt); else n_pass++;
        end
        e.word = model_word(seq, DIR_MSB_FIRST);
        e.perr = 1'b0;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
        drive_bit(1'b1, DIR_MSB_FIRST);
        e.perr = ~(^e.word);
`endif
        exp_q.push_back(e);
        e = exp_q.pop_front();
        n_total++; if (bus.word_out !== e.word) $display("FAIL msb_word got %h want %h", bus.word_out, e.word); else n_pass++;
        n_total++; if (bus.word_out !== 8'hB2) $display("FAIL msb_word_const got %h want b2", bus.word_out); else n_pass++;
        n_total++; if (bus.parity_err !== e.perr) $display("FAIL msb_perr got %b want %b", bus.parity_err, e.perr); else n_pass++;
        consume();
        $display("msb_first: word %h", e.word);
    endtask

    task automatic test_collision();
        logic [0:N-1] seq_a = N'($urandom);
        logic [0:N-1] seq_b = N'($urandom);
        exp_t e;
        send_word(seq_a, DIR_LSB_FIRST, 1'b0, 0);
        e = exp_q.pop_front();
        n_total++; if (bus.word_out !== e.word) $display("FAIL coll_first got %h want %h", bus.word_out, e.word); else n_pass++;
        for (int i = 0; i < N; i++) begin
`ifndef SERIAL_WORD_ASSEMBLER_PARITY_EN
            if (i == N - 1) bus.word_ready = 1'b1;
`endif
            drive_bit(seq_b[i], DIR_MSB_FIRST);
        end
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
        bus.word_ready = 1'b1;
        drive_bit(1'b0, DIR_MSB_FIRST);
`endif
        bus.word_ready = 1'b0;
        e.word = model_word(seq_b, DIR_MSB_FIRST);
        n_total++; if (bus.word_out !== e.word) $display("FAIL coll_word got %h want %h", bus.word_out, e.word); else n_pass++;
        n_total++; if (bus.word_valid !== 1'b1) $display("FAIL coll_valid got %b want 1", bus.word_valid); else n_pass++;
        n_total++; if (bus.overrun !== 1'b0) $display("FAIL coll_overrun got %b want 0", bus.overrun); else n_pass++;
        consume();
        $display("collision: word %h", e.word);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic d;
        bus.word_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            d = 1'($urandom);
            send_word(N'($urandom), d, 1'($urandom), 0);
            e = exp_q.pop_front();
            n_total++; if (bus.word_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got %b want 1", w, bus.word_valid); else n_pass++;
            n_total++; if (bus.word_out !== e.word) $display("FAIL b2b_word[%0d] got %h want %h", w, bus.word_out, e.word); else n_pass++;
            n_total++; if (bus.parity_err !== e.perr) $display("FAIL b2b_perr[%0d] got %b want %b", w, bus.parity_err, e.perr); else n_pass++;
            n_total++; if (bus.busy !== 1'b0) $display("FAIL b2b_busy[%0d] got %b want 0", w, bus.busy); else n_pass++;
            $display("back_to_back: word %0d = %h", w, e.word);
        end
        @(posedge clk); #1;
        bus.word_ready = 1'b0;
    endtask

    task automatic test_overrun();
        exp_t e;
        send_word(8'b10110010, DIR_LSB_FIRST, 1'b0, 0);
        send_word(8'b11111111, DIR_MSB_FIRST, 1'b0, 0);
        void'(exp_q.pop_back());
        e = exp_q.pop_front();
        n_total++; if (bus.word_out !== e.word) $display("FAIL ovr_word got %h want %h", bus.word_out, e.word); else n_pass++;
        n_total++; if (bus.word_out !== 8'h4D) $display("FAIL ovr_word_const got %h want 4d", bus.word_out); else n_pass++;
        n_total++; if (bus.overrun !== 1'b1) $display("FAIL ovr_flag got %b want 1", bus.overrun); else n_pass++;
        consume();
        n_total++; if (bus.word_valid !== 1'b0) $display("FAIL ovr_consume got %b want 0", bus.word_valid); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (bus.overrun !== 1'b1) $display("FAIL ovr_sticky got %b want 1", bus.overrun); else n_pass++;
        $display("overrun: held %h", e.word);
    endtask

    task automatic test_midword_reset();
        exp_t e;
        for (int i = 0; i < 3; i++) drive_bit(1'b1, DIR_MSB_FIRST);
        reset = 1'b1;
        #2;
        n_total++; if (bus.bit_cnt !== 4'd0) $display("FAIL mrst_bit_cnt got %0d want 0", bus.bit_cnt); else n_pass++;
        n_total++; if (bus.overrun !== 1'b0) $display("FAIL mrst_overrun got %b want 0", bus.overrun); else n_pass++;
        reset = 1'b0;
        @(posedge clk); #1;
        send_word(8'b11110000, DIR_LSB_FIRST, 1'b0, 0);
        e = exp_q.pop_front();
        n_total++; if (bus.word_out !== 8'h0F) $display("FAIL mrst_word got %h want 0f", bus.word_out); else n_pass++;
        n_total++; if (bus.word_out !== e.word) $display("FAIL mrst_model got %h want %h", bus.word_out, e.word); else n_pass++;
        n_total++; if (bus.overrun !== 1'b0) $display("FAIL mrst_no_ovr got %b want 0", bus.overrun); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL mrst_busy got %b want 0", bus.busy); else n_pass++;
        consume();
        $display("midword_reset: word %h", e.word);
    endtask

`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
    task automatic test_parity();
        exp_t e;
        for (int p = 1; p >= 0; p--) begin
            send_word(8'b10110010, DIR_LSB_FIRST, 1'(p), 0);
            e = exp_q.pop_front();
            n_total++; if (bus.parity_err !== 1'(p)) $display("FAIL par_err[%0d] got %b want %0d", p, bus.parity_err, p); else n_pass++;
            n_total++; if (bus.parity_err !== e.perr) $display("FAIL par_model[%0d] got %b want %b", p, bus.parity_err, e.perr); else n_pass++;
            n_total++; if (bus.word_valid !== 1'b1 || bus.word_out !== 8'h4D) $display("FAIL par_word[%0d] got %b/%h want 1/4d", p, bus.word_valid, bus.word_out); else n_pass++;
            consume();
            $display("parity: bit %0d perr %b", p, e.perr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_collision();
        test_back_to_back();
        test_overrun();
        test_midword_reset();
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
